// File: rtl/csr_trap_ctrl_if.sv
// CSR file access port driven by csr_trap_ctrl (master) and served by the CSR register file (slave).
interface csr_trap_ctrl_if;
    logic [31:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rd;
    logic        csr_wr;

    modport master (
        output csr_addr,
        output csr_wdata,
        output csr_rd,
        output csr_wr,
        input  csr_rdata
    );

    modport slave (
        input  csr_addr,
        input  csr_wdata,
        input  csr_rd,
        input  csr_wr,
        output csr_rdata
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/return sequencer that owns the CSR port while saving or restoring context.
// Define CSR_TRAP_EXT_IRQ_EN to service irq_ext (cause 11, priority over the timer).
module csr_trap_ctrl #(
    parameter logic [31:0] MTVEC    = 32'h0000_0100,
    parameter int unsigned POLL_GAP = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   irq_timer,
    input  logic                   irq_ext,
    input  logic                   mret,
    input  logic [31:0]            pc,
    csr_trap_ctrl_if.master        csr,
    output logic                   stall,
    output logic                   redirect_en,
    output logic [31:0]            redirect_pc
);

    localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] ADDR_MIE     = 32'h0000_0304;
    localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] ADDR_MIP     = 32'h0000_0344;
    localparam logic [7:0]  GAP_LOAD     = POLL_GAP[7:0];

    typedef enum logic [3:0] {
        IDLE,
        T_RD_MST,
        T_RD_MIE,
        T_WR_MEPC,
        T_WR_MIP,
        T_WR_MST,
        T_REDIR,
        R_RD_MEPC,
        R_RD_MST,
        R_WR_MST,
        R_REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [31:0] pc_q, pc_d;
    logic        cause_ext_q, cause_ext_d;
    logic [31:0] mst_q, mst_d;
    logic [31:0] mepc_q, mepc_d;

    logic        ext_req;
    logic        irq_any;
    logic        mie_hit;
    logic [31:0] cause_onehot;

`ifdef CSR_TRAP_EXT_IRQ_EN
    assign ext_req = irq_ext;
`else
    logic unused_irq_ext;
    assign ext_req        = 1'b0;
    assign unused_irq_ext = irq_ext;
`endif

    assign irq_any      = ext_req | irq_timer;
    assign mie_hit      = cause_ext_q ? csr.csr_rdata[11] : csr.csr_rdata[7];
    assign cause_onehot = cause_ext_q ? 32'h0000_0800 : 32'h0000_0080;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gap_q       <= 8'd0;
            pc_q        <= 32'd0;
            cause_ext_q <= 1'b0;
            mst_q       <= 32'd0;
            mepc_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            pc_q        <= pc_d;
            cause_ext_q <= cause_ext_d;
            mst_q       <= mst_d;
            mepc_q      <= mepc_d;
        end
    end

    // mret is checked first so a return always wins over a pending interrupt.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pc_d        = pc_q;
        cause_ext_d = cause_ext_q;
        mst_d       = mst_q;
        mepc_d      = mepc_q;

        case (state_q)
            IDLE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end
                if (mret) begin
                    state_d = R_RD_MEPC;
                    gap_d   = 8'd0;
                end else if (irq_any && (gap_q == 8'd0)) begin
                    state_d     = T_RD_MST;
                    pc_d        = pc;
                    cause_ext_d = ext_req;
                end
            end
            T_RD_MST: begin
                mst_d = csr.csr_rdata;
                if (!csr.csr_rdata[3]) begin
                    state_d = IDLE;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = T_RD_MIE;
                end
            end
            T_RD_MIE: begin
                if (!mie_hit) begin
                    state_d = IDLE;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = T_WR_MEPC;
                end
            end
            T_WR_MEPC: state_d = T_WR_MIP;
            T_WR_MIP:  state_d = T_WR_MST;
            T_WR_MST:  state_d = T_REDIR;
            T_REDIR:   state_d = IDLE;
            R_RD_MEPC: begin
                mepc_d  = csr.csr_rdata;
                state_d = R_RD_MST;
            end
            R_RD_MST: begin
                mst_d   = csr.csr_rdata;
                state_d = R_WR_MST;
            end
            R_WR_MST:  state_d = R_REDIR;
            R_REDIR:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Moore outputs: everything is a function of the current state and the latched context.
    always_comb begin
        csr.csr_addr  = 32'd0;
        csr.csr_wdata = 32'd0;
        csr.csr_rd    = 1'b0;
        csr.csr_wr    = 1'b0;
        redirect_en   = 1'b0;
        redirect_pc   = 32'd0;
        stall         = (state_q != IDLE);

        case (state_q)
            T_RD_MST, R_RD_MST: begin
                csr.csr_rd   = 1'b1;
                csr.csr_addr = ADDR_MSTATUS;
            end
            T_RD_MIE: begin
                csr.csr_rd   = 1'b1;
                csr.csr_addr = ADDR_MIE;
            end
            T_WR_MEPC: begin
                csr.csr_wr    = 1'b1;
                csr.csr_addr  = ADDR_MEPC;
                csr.csr_wdata = pc_q;
            end
            T_WR_MIP: begin
                csr.csr_wr    = 1'b1;
                csr.csr_addr  = ADDR_MIP;
                csr.csr_wdata = cause_onehot;
            end
            T_WR_MST: begin
                csr.csr_wr    = 1'b1;
                csr.csr_addr  = ADDR_MSTATUS;
                csr.csr_wdata = {mst_q[31:8], mst_q[3], mst_q[6:4], 1'b0, mst_q[2:0]};
            end
            T_REDIR: begin
                redirect_en = 1'b1;
                redirect_pc = MTVEC;
            end
            R_RD_MEPC: begin
                csr.csr_rd   = 1'b1;
                csr.csr_addr = ADDR_MEPC;
            end
            R_WR_MST: begin
                csr.csr_wr    = 1'b1;
                csr.csr_addr  = ADDR_MSTATUS;
                csr.csr_wdata = {mst_q[31:8], 1'b1, mst_q[6:4], mst_q[7], mst_q[2:0]};
            end
            R_REDIR: begin
                redirect_en = 1'b1;
                redirect_pc = mepc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file on the slave side of the port.
module tb_csr_trap_ctrl;

    logic        clk;
    logic        rst;
    logic        irq_timer;
    logic        irq_ext;
    logic        mret;
    logic [31:0] pc;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    csr_trap_ctrl_if bus ();

    csr_trap_ctrl #(
        .MTVEC    (32'h0000_0100),
        .POLL_GAP (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_timer   (irq_timer),
        .irq_ext     (irq_ext),
        .mret        (mret),
        .pc          (pc),
        .csr         (bus.master),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
    );

    int checks;
    int errors;

    logic [31:0] m_mst, m_mie, m_mepc, m_mip;
    logic        pl_en;
    logic [31:0] pl_mst, pl_mie, pl_mepc, pl_mip;

    logic [31:0] exp_mip_cause;
    int          reads, writes, redirs, stalls, first_rd, second_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: combinational read, write committed on the rising edge.
    always_comb begin
        bus.csr_rdata = 32'h0;
        case (bus.csr_addr)
            32'h300: bus.csr_rdata = m_mst;
            32'h304: bus.csr_rdata = m_mie;
            32'h341: bus.csr_rdata = m_mepc;
            32'h344: bus.csr_rdata = m_mip;
            default: bus.csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) begin
            m_mst  <= pl_mst;
            m_mie  <= pl_mie;
            m_mepc <= pl_mepc;
            m_mip  <= pl_mip;
        end else if (bus.csr_wr) begin
            case (bus.csr_addr)
                32'h300: m_mst  <= bus.csr_wdata;
                32'h304: m_mie  <= bus.csr_wdata;
                32'h341: m_mepc <= bus.csr_wdata;
                32'h344: m_mip  <= bus.csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic t, input logic e, input logic m, input logic [31:0] p);
        irq_timer = t;
        irq_ext   = e;
        mret      = m;
        pc        = p;
    endtask

    task automatic loadCsr(input logic [31:0] mst, input logic [31:0] mie,
                           input logic [31:0] mepc, input logic [31:0] mip);
        pl_mst  = mst;
        pl_mie  = mie;
        pl_mepc = mepc;
        pl_mip  = mip;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag, input logic s, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        checkOutput({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
        checkOutput({tag, ".rd"},    {31'd0, bus.csr_rd}, {31'd0, rd});
        checkOutput({tag, ".wr"},    {31'd0, bus.csr_wr}, {31'd0, wr});
        checkOutput({tag, ".addr"},  bus.csr_addr, addr);
        checkOutput({tag, ".wdata"}, bus.csr_wdata, wdata);
    endtask

    task automatic checkRedirect(input string tag, input logic en, input logic [31:0] target);
        checkOutput({tag, ".redir_en"}, {31'd0, redirect_en}, {31'd0, en});
        checkOutput({tag, ".redir_pc"}, redirect_pc, target);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        pl_en  = 1'b0;
        pl_mst = 32'h0; pl_mie = 32'h0; pl_mepc = 32'h0; pl_mip = 32'h0;
`ifdef CSR_TRAP_EXT_IRQ_EN
        exp_mip_cause = 32'h0000_0800;
`else
        exp_mip_cause = 32'h0000_0080;
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checkBus("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("reset", 1'b0, 32'h0);

        tick();
        rst = 1'b1;
        $display("[TB] accepted timer trap");
        loadCsr(32'h8, 32'h80, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0040);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBus("trap.t1", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick(); checkBus("trap.t2", 1'b1, 1'b1, 1'b0, 32'h304, 32'h0);
        tick(); checkBus("trap.t3", 1'b1, 1'b0, 1'b1, 32'h341, 32'h40);
        tick(); checkBus("trap.t4", 1'b1, 1'b0, 1'b1, 32'h344, 32'h80);
        tick(); checkBus("trap.t5", 1'b1, 1'b0, 1'b1, 32'h300, 32'h80);
        tick(); checkBus("trap.t6", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("trap.t6", 1'b1, 32'h100);
        tick(); checkBus("trap.t7", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("trap.t7", 1'b0, 32'h0);
        checkOutput("trap.mepc", m_mepc, 32'h40);
        checkOutput("trap.mip", m_mip, 32'h80);
        checkOutput("trap.mstatus", m_mst, 32'h80);

        $display("[TB] mret return");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBus("ret.t1", 1'b1, 1'b1, 1'b0, 32'h341, 32'h0);
        tick(); checkBus("ret.t2", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick(); checkBus("ret.t3", 1'b1, 1'b0, 1'b1, 32'h300, 32'h88);
        tick(); checkBus("ret.t4", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("ret.t4", 1'b1, 32'h40);
        tick(); checkBus("ret.t5", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("ret.mstatus", m_mst, 32'h88);

        $display("[TB] rejected polls with MIE clear");
        loadCsr(32'h0, 32'h80, 32'h40, 32'h80);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0040);
        reads = 0; writes = 0; redirs = 0; stalls = 0; first_rd = -1; second_rd = -1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (bus.csr_rd && bus.csr_addr == 32'h300) begin
                reads++;
                if (first_rd < 0) first_rd = i;
                else if (second_rd < 0) second_rd = i;
            end
            if (bus.csr_wr) writes++;
            if (redirect_en) redirs++;
            if (stall) stalls++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("poll.reads", reads, 32'd3);
        checkOutput("poll.first", first_rd, 32'd1);
        checkOutput("poll.period", second_rd - first_rd, 32'd10);
        checkOutput("poll.writes", writes, 32'd0);
        checkOutput("poll.redirects", redirs, 32'd0);
        checkOutput("poll.stalls", stalls, 32'd3);
        repeat (8) tick();

        $display("[TB] mie reject then mret inside the gap");
        loadCsr(32'h8, 32'h0, 32'h40, 32'h80);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBus("miej.t1", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick(); checkBus("miej.t2", 1'b1, 1'b1, 1'b0, 32'h304, 32'h0);
        tick(); checkBus("miej.t3", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBus("gapret.t1", 1'b1, 1'b1, 1'b0, 32'h341, 32'h0);
        tick();
        tick(); checkBus("gapret.t3", 1'b1, 1'b0, 1'b1, 32'h300, 32'h80);
        tick(); checkRedirect("gapret.t4", 1'b1, 32'h40);
        tick(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBus("gapclr.t1", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        repeat (11) tick();

        $display("[TB] mret/irq collision, ext priority, reset mid-trap");
        loadCsr(32'h80, 32'h880, 32'h40, 32'h80);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1234_5670);
        tick(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h1234_5670);
        checkBus("coll.t1", 1'b1, 1'b1, 1'b0, 32'h341, 32'h0);
        tick();
        tick(); checkBus("coll.t3", 1'b1, 1'b0, 1'b1, 32'h300, 32'h88);
        tick(); checkRedirect("coll.t4", 1'b1, 32'h40);
        tick(); checkBus("coll.t5", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); applyStimulus(1'b0, 1'b0, 1'b0, 32'h1234_5670);
        checkBus("prio.t1", 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        tick(); checkBus("prio.t2", 1'b1, 1'b1, 1'b0, 32'h304, 32'h0);
        tick(); checkBus("prio.t3", 1'b1, 1'b0, 1'b1, 32'h341, 32'h1234_5670);
        tick(); checkBus("prio.t4", 1'b1, 1'b0, 1'b1, 32'h344, exp_mip_cause);
        #2 rst = 1'b0;
        #1;
        checkBus("rstmid", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("rstmid", 1'b0, 32'h0);
        tick();
        checkOutput("rstmid.mepc", m_mepc, 32'h1234_5670);
        checkOutput("rstmid.mstatus", m_mst, 32'h88);
        checkOutput("rstmid.mip", m_mip, 32'h80);
        rst = 1'b1;
        tick();
        checkBus("post", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkRedirect("post", 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode trap sequencer that drives the CSR register file's access port as its initiator. It samples timer and external interrupt requests and `mret` and checks `mstatus.MIE` and `mie`. It then issues the ordered CSR read/write sequence to save or restore context, and emits a one-cycle PC redirect to the trap vector or to the saved `mepc`. It sits between the core's decode/fetch stages and the CSR file, and stalls the pipeline while it owns the CSR port.

## Interface
- `MTVEC`, 32'h0000_0100: fixed trap vector; this is the redirect target on trap entry.
- `POLL_GAP`, 8: number of idle cycles after a rejected interrupt poll before the block polls again (1..255).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `irq_timer`  in  1  level-sensitive machine timer interrupt request.
- `irq_ext`  in  1  level-sensitive machine external interrupt request.
- `mret`  in  1  one-cycle pulse from decode; an `mret` has retired.
- `pc`  in  32  PC of the instruction to resume after the trap.
- `csr_rdata`  in  32  read data from the CSR file; combinational, valid in the same cycle as `csr_addr`/`csr_rd`.
- `csr_addr`  out  32  CSR address; only 12'h300, 12'h304, 12'h341 and 12'h344 are ever driven, zero-extended.
- `csr_wdata`  out  32  CSR write data.
- `csr_rd`  out  1  CSR read strobe.
- `csr_wr`  out  1  CSR write strobe; the CSR file commits the write on the next rising edge.
- `stall`  out  1  high in every non-IDLE state.
- `redirect_en`  out  1  one-cycle PC redirect strobe.
- `redirect_pc`  out  32  redirect target; valid while `redirect_en` is high, 0 otherwise.

## Operation
- Outputs are Moore-decoded from the state. While not in the listed access states, `csr_rd`, `csr_wr`, `csr_addr` and `csr_wdata` are all 0.
- Trap path: IDLE → T_RD_MST → T_RD_MIE → T_WR_MEPC → T_WR_MIP → T_WR_MST → T_REDIR → IDLE.
  - IDLE leaves for T_RD_MST when an enabled source (`irq_ext`, or `irq_timer`) is high and the gap counter is 0. On that edge, latch `pc` and the cause: external = bit 11, timer = bit 7. External has priority over timer.
  - T_RD_MST reads 12'h300 and latches `csr_rdata`. If bit 3 (MIE) is 0, go to IDLE and load the gap counter with POLL_GAP.
  - T_RD_MIE reads 12'h304. If the `mie` bit for the latched cause is 0, go to IDLE and load the gap counter; otherwise continue.
  - T_WR_MEPC writes the latched pc to 12'h341.
  - T_WR_MIP writes the one-hot cause bit to 12'h344.
  - T_WR_MST writes the latched mstatus to 12'h300 with bit 3 = 0 and bit 7 (MPIE) = the old bit 3.
  - T_REDIR drives `redirect_en`=1 and `redirect_pc`=MTVEC.
- Return path: IDLE → R_RD_MEPC → R_RD_MST → R_WR_MST → R_REDIR → IDLE.
  - R_RD_MEPC reads 12'h341 and latches the value.
  - R_RD_MST reads 12'h300 and latches the value.
  - R_WR_MST writes mstatus with bit 3 = the old bit 7, and bit 7 = 1.
  - R_REDIR drives `redirect_en`=1 and `redirect_pc` = the latched mepc.
- Arbitration in IDLE: `mret` beats an interrupt. A pending interrupt is evaluated again once the block returns to IDLE.
- `mret` and interrupt requests are ignored in every non-IDLE state; an `mret` pulse arriving there is lost.
- Gap counter: 8-bit, decrements by 1 per cycle while in IDLE and nonzero. While it is nonzero it blocks interrupt entry but does not block `mret`. Entering the return path clears it.

## Timing
- Reset (`rst`=0) forces, asynchronously: state IDLE, all outputs 0, gap counter 0, all latches 0. If reset is asserted mid-sequence, CSR writes already clocked remain in the CSR file and the remaining writes are not issued.
- Trap, accepted: request seen in IDLE at cycle T0. `stall` is high T1..T6. CSR accesses occur in T1..T5, `redirect_en` pulses in T6, and the block is back in IDLE at T7.
- Trap, rejected at mstatus: `stall` high for T1 only. Rejected at mie: `stall` high for T1..T2. In both cases the next poll happens no earlier than POLL_GAP cycles after the return to IDLE.
- `mret` seen in IDLE at T0: `stall` high T1..T4, `redirect_en` pulses in T4, the block is back in IDLE at T5.
- Read data is sampled at the clock edge that ends each read state. There is no wait state.

## Configuration
- `CSR_TRAP_EXT_IRQ_EN` defined: `irq_ext` is serviced (cause bit 11, `mie` bit 11 checked, priority over timer).
- Not defined: the `irq_ext` port is still present but ignored. Only the timer source exists, and bit 11 is never written to `mip`.

## Test plan
- Accepted timer trap: preload mstatus=32'h8, mie=32'h80; `irq_timer`=1 with pc=32'h0000_0040 → mepc=32'h40, mip=32'h80, mstatus=32'h80, `redirect_pc`=32'h100 at T6, `stall` high for exactly 6 cycles.
- Rejected poll: mstatus=32'h0, `irq_timer` held at 1 → a 12'h300 read occurs every 1+POLL_GAP+1 cycles, with no writes and no redirect.
- Return: after the accepted trap above, pulse `mret` → mstatus=32'h88, `redirect_pc`=32'h40 at T4, `stall` high for 4 cycles.
- Priority and collision: with the macro defined, assert `irq_timer` and `irq_ext` together → mip=32'h800. Assert `mret` and `irq_timer` in the same cycle → the return path runs first.
- Reset mid-trap: drive `rst` low during T_WR_MIP → outputs go to 0 immediately and the state is IDLE. mepc holds the new pc, mstatus is unchanged.
